// File: rtl/usb_buffer_pkg.sv
// Shared constants and types for the USB byte buffer.
package usb_buffer_pkg;
    localparam int unsigned BUF_DEPTH  = 64;
    localparam int unsigned BUF_DATA_W = 8;
    localparam int unsigned BUF_OCC_W  = $clog2(BUF_DEPTH) + 1;

    typedef logic [7:0] byte_t;
endpackage

// File: rtl/usb_buffer_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
module usb_buffer_ptr
    import usb_buffer_pkg::*;
#(
    parameter int unsigned PTR_W = $clog2(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Pointer width equals log2(DEPTH), so the natural overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/usb_data_buffer.sv
// Shared first-word-fall-through byte FIFO between the AHB slave and the USB
// packet engines, with occupancy reporting, flush and a sticky error flag.
module usb_data_buffer
    import usb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = BUF_DEPTH,
    parameter int unsigned DATA_W = BUF_DATA_W,
    parameter int unsigned OCC_W  = BUF_OCC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              get_rx_data,
    output logic [DATA_W-1:0] rx_data,
    input  logic              store_rx_packet_data,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              get_tx_packet_data,
    output logic [DATA_W-1:0] tx_packet_data,
    output logic [OCC_W-1:0]  buffer_occupancy,
    output logic              buf_full,
    output logic              buf_empty,
    output logic              buf_error
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [OCC_W-1:0]  r_occ;
    logic              r_error;

    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_err_evt;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_head;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == OCC_W'(DEPTH));

    // AHB write has priority over the USB RX write on a collision.
    assign w_wr_req  = store_tx_data | store_rx_packet_data;
    assign w_wr_data = store_tx_data ? tx_data : rx_packet_data;
    assign w_rd_req  = get_rx_data | get_tx_packet_data;

    // A write at full is still accepted when a read frees the head slot.
    assign w_rd_en = ~rst & ~clear & w_rd_req & ~w_empty;
    assign w_wr_en = ~rst & ~clear & w_wr_req & (~w_full | w_rd_en);

    assign w_err_evt = (store_tx_data & store_rx_packet_data)
                     | (get_rx_data & get_tx_packet_data)
                     | (w_wr_req & w_full & ~w_rd_en)
                     | (w_rd_req & w_empty);

    usb_buffer_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (w_wr_en),
        .ptr (w_wr_ptr)
    );

    usb_buffer_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (w_rd_en),
        .ptr (w_rd_ptr)
    );

    // Storage is intentionally not reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_occ <= '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_error <= 1'b0;
        end else if (w_err_evt) begin
            r_error <= 1'b1;
        end
    end

    assign w_head = w_empty ? '0 : r_mem[w_rd_ptr];

    assign rx_data          = w_head;
    assign tx_packet_data   = w_head;
    assign buffer_occupancy = r_occ;
    assign buf_full         = w_full;
    assign buf_empty        = w_empty;
    assign buf_error        = r_error;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer against a queue-based reference model.
module tb_usb_data_buffer;
    import usb_buffer_pkg::*;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       store_tx_data = 1'b0;
    byte_t      tx_data = '0;
    logic       get_rx_data = 1'b0;
    byte_t      rx_data;
    logic       store_rx_packet_data = 1'b0;
    byte_t      rx_packet_data = '0;
    logic       get_tx_packet_data = 1'b0;
    byte_t      tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       buf_full;
    logic       buf_empty;
    logic       buf_error;

    int total = 0;
    int bad   = 0;

    byte_t q[$];
    bit    m_err;

    usb_data_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .buf_full             (buf_full),
        .buf_empty            (buf_empty),
        .buf_error            (buf_error)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus a sticky error bit.
    task automatic model_step();
        bit wr_req, rd_req, rd_eff, wr_eff;
        if (rst || clear) begin
            q.delete();
            m_err = 1'b0;
            return;
        end
        wr_req = store_tx_data || store_rx_packet_data;
        rd_req = get_rx_data || get_tx_packet_data;
        rd_eff = rd_req && (q.size() > 0);
        wr_eff = wr_req && ((q.size() < DEPTH) || rd_eff);
        if (store_tx_data && store_rx_packet_data) m_err = 1'b1;
        if (get_rx_data && get_tx_packet_data)     m_err = 1'b1;
        if (wr_req && !wr_eff)                     m_err = 1'b1;
        if (rd_req && q.size() == 0)               m_err = 1'b1;
        if (rd_eff) void'(q.pop_front());
        if (wr_eff) q.push_back(store_tx_data ? tx_data : rx_packet_data);
    endtask

    // Drive one clock of stimulus; outputs are sampled 1ns after the edge.
    task automatic cyc(input bit r, input bit clr, input bit st, input byte_t td,
                       input bit sr, input byte_t rd, input bit grx, input bit gtx);
        rst = r; clear = clr;
        store_tx_data = st; tx_data = td;
        store_rx_packet_data = sr; rx_packet_data = rd;
        get_rx_data = grx; get_tx_packet_data = gtx;
        model_step();
        @(posedge clk);
        #1;
        rst = 1'b0; clear = 1'b0;
        store_tx_data = 1'b0; store_rx_packet_data = 1'b0;
        get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
    endtask

    function automatic byte_t m_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (buffer_occupancy !== 7'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", buffer_occupancy); end
        total++; if (buf_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", buf_empty); end
        total++; if (buf_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", buf_full); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        total++; if (tx_packet_data !== 8'h00) begin bad++; $display("FAIL reset_tx_pkt got=%h exp=00", tx_packet_data); end
        total++; if (buf_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", buf_error); end
    endtask

    task automatic test_ahb_order();
        byte_t exp_b [3];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, exp_b[i], 0, 0, 0, 0);
        total++; if (buffer_occupancy !== 7'd3) begin bad++; $display("FAIL ahb_occ got=%0d exp=3", buffer_occupancy); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (tx_packet_data !== exp_b[i]) begin bad++; $display("FAIL ahb_order[%0d] got=%h exp=%h", i, tx_packet_data, exp_b[i]); end
            cyc(0, 0, 0, 0, 0, 0, 0, 1);
        end
        total++; if (buffer_occupancy !== 7'd0 || buf_empty !== 1'b1) begin bad++; $display("FAIL ahb_drained got occ=%0d empty=%b exp occ=0 empty=1", buffer_occupancy, buf_empty); end
        total++; if (buf_error !== 1'b0) begin bad++; $display("FAIL ahb_err got=%b exp=0", buf_error); end
    endtask

    task automatic test_fill_overflow();
        byte_t v;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, byte_t'(i), 0, 0);
        total++; if (buf_full !== 1'b1 || buffer_occupancy !== 7'd64) begin bad++; $display("FAIL fill_full got full=%b occ=%0d exp full=1 occ=64", buf_full, buffer_occupancy); end
        total++; if (buf_error !== 1'b0) begin bad++; $display("FAIL fill_err got=%b exp=0", buf_error); end
        cyc(0, 0, 0, 0, 1, 8'hEE, 0, 0);
        total++; if (buf_error !== 1'b1 || buffer_occupancy !== 7'd64) begin bad++; $display("FAIL overflow got err=%b occ=%0d exp err=1 occ=64", buf_error, buffer_occupancy); end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (rx_data !== byte_t'(i)) begin bad++; $display("FAIL drain[%0d] got=%h exp=%h", i, rx_data, byte_t'(i)); end
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
        end
        total++; if (buf_empty !== 1'b1 || rx_data !== 8'h00) begin bad++; $display("FAIL drain_empty got empty=%b rx=%h exp empty=1 rx=00", buf_empty, rx_data); end
        for (int i = 0; i < 10; i++) begin
            v = byte_t'($urandom_range(0, 255));
            cyc(0, 0, 0, 0, 1, v, 0, 0);
            total++;
            if (rx_data !== v || buffer_occupancy !== 7'd1) begin bad++; $display("FAIL wrap[%0d] got rx=%h occ=%0d exp rx=%h occ=1", i, rx_data, buffer_occupancy, v); end
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_full_simul();
        byte_t exp_head;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, byte_t'($urandom_range(0, 255)), 0, 0, 0, 0);
        cyc(0, 0, 1, 8'h55, 0, 0, 1, 0);
        total++; if (buffer_occupancy !== 7'd64 || buf_full !== 1'b1) begin bad++; $display("FAIL full_rw_occ got=%0d exp=64", buffer_occupancy); end
        total++; if (buf_error !== 1'b0) begin bad++; $display("FAIL full_rw_err got=%b exp=0", buf_error); end
        for (int i = 0; i < DEPTH; i++) begin
            exp_head = m_head();
            total++;
            if (rx_data !== exp_head) begin bad++; $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, rx_data, exp_head); end
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_collision_clear();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 8'h11, 1, 8'h22, 0, 0);
        total++; if (buffer_occupancy !== 7'd1 || rx_data !== 8'h11) begin bad++; $display("FAIL collide got occ=%0d rx=%h exp occ=1 rx=11", buffer_occupancy, rx_data); end
        total++; if (buf_error !== 1'b1) begin bad++; $display("FAIL collide_err got=%b exp=1", buf_error); end
        cyc(0, 1, 1, 8'h33, 0, 0, 1, 0);
        total++; if (buffer_occupancy !== 7'd0 || buf_error !== 1'b0 || buf_empty !== 1'b1) begin bad++; $display("FAIL clear got occ=%0d err=%b empty=%b exp 0/0/1", buffer_occupancy, buf_error, buf_empty); end
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        total++; if (buf_error !== 1'b1 || buffer_occupancy !== 7'd0) begin bad++; $display("FAIL dual_read_empty got err=%b occ=%0d exp err=1 occ=0", buf_error, buffer_occupancy); end
    endtask

    task automatic test_underflow_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        total++; if (buf_error !== 1'b1 || buffer_occupancy !== 7'd0 || rx_data !== 8'h00) begin bad++; $display("FAIL underflow got err=%b occ=%0d rx=%h exp 1/0/00", buf_error, buffer_occupancy, rx_data); end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 8'h7C, 0, 0, 0, 1);
        total++; if (buffer_occupancy !== 7'd1 || tx_packet_data !== 8'h7C || buf_error !== 1'b1) begin bad++; $display("FAIL wr_rd_empty got occ=%0d tx=%h err=%b exp 1/7c/1", buffer_occupancy, tx_packet_data, buf_error); end
        for (int i = 0; i < 19; i++) cyc(0, 0, 0, 0, 1, byte_t'(i), 0, 0);
        total++; if (buffer_occupancy !== 7'd20) begin bad++; $display("FAIL pre_rst_occ got=%0d exp=20", buffer_occupancy); end
        cyc(1, 0, 1, 8'h44, 0, 0, 1, 0);
        total++; if (buffer_occupancy !== 7'd0 || buf_empty !== 1'b1 || buf_error !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL mid_rst got occ=%0d empty=%b err=%b rx=%h exp 0/1/0/00", buffer_occupancy, buf_empty, buf_error, rx_data); end
    endtask

    task automatic test_random();
        bit r, clr, st, sr, grx, gtx;
        int mode;
        byte_t eh;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            mode = (n / 300) % 3;
            r   = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 149) == 0);
            st  = ($urandom_range(0, 9) < (mode == 0 ? 7 : (mode == 1 ? 2 : 4)));
            sr  = ($urandom_range(0, 9) < (mode == 0 ? 2 : 1));
            grx = ($urandom_range(0, 9) < (mode == 1 ? 6 : 3));
            gtx = ($urandom_range(0, 9) < (mode == 1 ? 2 : 1));
            cyc(r, clr, st, byte_t'($urandom), sr, byte_t'($urandom), grx, gtx);
            eh = m_head();
            total++;
            if (buffer_occupancy !== 7'(q.size()) || rx_data !== eh || tx_packet_data !== eh
                || buf_full !== (q.size() == DEPTH) || buf_empty !== (q.size() == 0)
                || buf_error !== m_err) begin
                bad++;
                $display("FAIL rand[%0d] got occ=%0d rx=%h tx=%h full=%b empty=%b err=%b exp occ=%0d head=%h err=%b",
                         n, buffer_occupancy, rx_data, tx_packet_data, buf_full, buf_empty, buf_error,
                         q.size(), eh, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ahb_order();
        test_fill_overflow();
        test_full_simul();
        test_collision_clear();
        test_underflow_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
